// File: rtl/factorial_pkg.sv
// Shared types and constants for the iterative factorial sequencer.
// The sequencer drives the shared ALU multiplier selected by OP_FACT_MUL.
package factorial_pkg;

  localparam int DATA_W = 16;
  localparam int VAL_W  = 9;

  localparam logic [5:0] OP_FACT_MUL = 6'b011101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/factorial_if.sv
// Operand, request and ALU-facing signals between the factorial sequencer and its parent.
// The master side is the parent, which owns val and FACT and models the ALU register.
interface factorial_if #(
  parameter int DATA_W = factorial_pkg::DATA_W,
  parameter int VAL_W  = factorial_pkg::VAL_W
);

  logic [VAL_W-1:0]  val;
  logic              FACT;
  logic [DATA_W-1:0] ALU_mul;
  logic [DATA_W-1:0] fact_out;
  logic [VAL_W-1:0]  current_iteration;
  logic              FACT_END;

  modport master (
    output val, FACT, ALU_mul,
    input  fact_out, current_iteration, FACT_END
  );

  modport slave (
    input  val, FACT, ALU_mul,
    output fact_out, current_iteration, FACT_END
  );

endinterface

// File: rtl/factorial.sv
// Iterative factorial sequencer: feeds the running product back through the ALU
// multiplier with a decrementing iteration count until val! sits on ALU_mul.
module factorial
  import factorial_pkg::*;
#(
  parameter int DATA_W = factorial_pkg::DATA_W,
  parameter int VAL_W  = factorial_pkg::VAL_W
) (
  input  logic        clk,
  input  logic        rst,
  factorial_if.slave  bus
);

  localparam logic [VAL_W-1:0]  ITER_ONE = VAL_W'(1);
  localparam logic [VAL_W-1:0]  ITER_TWO = VAL_W'(2);
  localparam logic [DATA_W-1:0] PROD_ONE = DATA_W'(1);

  state_e           state_q, state_d;
  logic [VAL_W-1:0] iter_q, iter_d;

  // Up to 2! the first multiply 1*max(val,1) already yields the result.
  logic val_trivial;
  assign val_trivial = (bus.val <= ITER_TWO);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

  // NOTE: defaults up front keep every path assigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    unique case (state_q)
      IDLE: begin
        if (bus.FACT) begin
          if (val_trivial) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            iter_d  = bus.val - ITER_ONE;
          end
        end
      end
      RUN: begin
        if (!bus.FACT) begin
          state_d = IDLE;
        end else begin
          iter_d = iter_q - ITER_ONE;
          if (iter_q == ITER_TWO) state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.FACT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // In DONE the multiplier stays at 1 so the ALU keeps re-registering the result.
  always_comb begin
    bus.fact_out          = PROD_ONE;
    bus.current_iteration = ITER_ONE;
    bus.FACT_END          = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.fact_out          = PROD_ONE;
        bus.current_iteration = (bus.val <= ITER_ONE) ? ITER_ONE : bus.val;
      end
      RUN: begin
        bus.fact_out          = bus.ALU_mul;
        bus.current_iteration = iter_q;
      end
      DONE: begin
        bus.fact_out          = bus.ALU_mul;
        bus.current_iteration = ITER_ONE;
        bus.FACT_END          = 1'b1;
      end
      default: begin
        bus.fact_out          = PROD_ONE;
        bus.current_iteration = ITER_ONE;
      end
    endcase
  end

endmodule

// File: tb/tb_factorial.sv
// Bench for the factorial sequencer paired with a registered ALU multiplier model;
// a scoreboard queue holds expected products and latencies for the end-of-run monitor.
module tb_factorial;

  localparam int DATA_W = 16;
  localparam int VAL_W  = 9;

  typedef struct {
    int product;
    int latency;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [DATA_W-1:0] alu_q = '0;
  logic              end_q = 1'b0;
  int                edges = 0;

  factorial_if #(.DATA_W(DATA_W), .VAL_W(VAL_W)) bus ();

  factorial #(.DATA_W(DATA_W), .VAL_W(VAL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ALU multiply stage: registers fact_out * zero-extended current_iteration.
  always @(posedge clk) alu_q <= DATA_W'(32'(bus.fact_out) * 32'(bus.current_iteration));
  assign bus.ALU_mul = alu_q;

  // Edges seen since the current request started.
  always @(posedge clk or negedge rst) begin
    if (!rst)          edges <= 0;
    else if (bus.FACT) edges <= edges + 1;
    else               edges <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each rising FACT_END must match the oldest scoreboard entry.
  always @(negedge clk) begin
    end_q <= bus.FACT_END;
    if (bus.FACT_END && !end_q) begin
      if (sb.size() == 0) begin
        check("unexpected_fact_end", 32'(bus.ALU_mul), 32'hFFFF_FFFF);
      end else begin
        check("sb_product", 32'(bus.ALU_mul), 32'(sb[0].product));
        check("sb_latency", 32'(edges), 32'(sb[0].latency));
        sb.delete(0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_end(input string name);
    int n = 0;
    while (!bus.FACT_END && n < 40) begin
      step();
      n++;
    end
    check({name, "_done"}, 32'(bus.FACT_END), 32'd1);
  endtask

  task automatic run_fact(input int v, input int prod, input int lat, input bit poke);
    bus.val = VAL_W'(v);
    sb.push_back('{product: prod, latency: lat});
    bus.FACT = 1'b1;
    if (poke) begin
      step();
      step();
      bus.val = VAL_W'(3);
    end
    wait_end("run");
    check("run_product", 32'(bus.ALU_mul), 32'(prod));
    step();
    check("run_hold", 32'(bus.ALU_mul), 32'(prod));
    bus.FACT = 1'b0;
    step();
    check("run_idle_end", 32'(bus.FACT_END), 32'd0);
  endtask

  int seq5[4] = '{5, 20, 60, 120};

  initial begin
    bus.val  = VAL_W'(5);
    bus.FACT = 1'b1;
    #1;
    check("rst_fact_end", 32'(bus.FACT_END), 32'd0);
    check("rst_fact_out", 32'(bus.fact_out), 32'd1);
    check("rst_iteration", 32'(bus.current_iteration), 32'd5);

    // val=5 started straight out of reset: 5, 20, 60, 120 on edges 1-4.
    sb.push_back('{product: 120, latency: 4});
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("seq5", 32'(bus.ALU_mul), 32'(seq5[k]));
      check("seq5_end", 32'(bus.FACT_END), (k == 3) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      check("seq5_hold", 32'(bus.ALU_mul), 32'd120);
      check("seq5_hold_end", 32'(bus.FACT_END), 32'd1);
    end
    bus.FACT = 1'b0;
    step();
    check("seq5_release", 32'(bus.FACT_END), 32'd0);

    run_fact(0, 1, 1, 1'b0);
    run_fact(1, 1, 1, 1'b0);
    run_fact(2, 2, 1, 1'b0);
    run_fact(3, 6, 2, 1'b0);
    run_fact(7, 5040, 6, 1'b0);
    run_fact(8, 40320, 7, 1'b1);
    run_fact(9, 35200, 8, 1'b0);

    // Abort after two edges, then restart from scratch.
    bus.val  = VAL_W'(5);
    bus.FACT = 1'b1;
    step();
    step();
    check("abort_mid", 32'(bus.ALU_mul), 32'd20);
    bus.FACT = 1'b0;
    step();
    check("abort_end", 32'(bus.FACT_END), 32'd0);
    check("abort_fact_out", 32'(bus.fact_out), 32'd1);
    sb.push_back('{product: 120, latency: 4});
    bus.FACT = 1'b1;
    step();
    check("restart_first", 32'(bus.ALU_mul), 32'd5);
    wait_end("restart");
    check("restart_product", 32'(bus.ALU_mul), 32'd120);
    bus.FACT = 1'b0;
    step();

    // Asynchronous reset mid-run takes effect without a clock edge.
    bus.FACT = 1'b1;
    step();
    step();
    #1;
    rst = 1'b0;
    #1;
    check("arst_fact_end", 32'(bus.FACT_END), 32'd0);
    check("arst_fact_out", 32'(bus.fact_out), 32'd1);
    check("arst_iteration", 32'(bus.current_iteration), 32'd5);
    sb.push_back('{product: 120, latency: 4});
    rst = 1'b1;
    wait_end("post_rst");
    check("post_rst_product", 32'(bus.ALU_mul), 32'd120);
    bus.FACT = 1'b0;
    step();
    step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
